// File: rtl/fpu_addsub_seq.sv
// Multi-cycle float add/subtract: IDLE -> ALIGN -> ADD -> NORM -> DONE, result held until consumed.
// Define FPU_ROUND_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fpu_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         operation,
    input  logic [W-1:0] operA,
    input  logic [W-1:0] operB,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result
);
    localparam int EXT_W  = MAN_W + 4;   // hidden bit + mantissa + guard/round/sticky
    localparam int SUM_W  = EXT_W + 1;   // plus one carry bit
    localparam int SH_LIM = MAN_W + 3;
    localparam int LZC_W  = $clog2(EXT_W + 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    state_t           state_reg;
    logic [W-1:0]     a_reg, b_reg;
    logic             op_reg;
    logic             sign_l_reg, eff_sub_reg, special_reg;
    logic [EXP_W-1:0] exp_l_reg;
    logic [EXT_W-1:0] sig_l_reg, sig_s_reg;
    logic [W-1:0]     special_val_reg;
    logic [SUM_W-1:0] sum_reg;

    // ---------------- alignment (operates on captured operands) ----------------
    logic [EXP_W-1:0]        ea, eb, el, es, diff;
    logic [MAN_W-1:0]        ma, mb;
    logic                    sa, sb_eff, a_max, b_max, a_nan, b_nan, a_inf, b_inf;
    logic                    swap, sign_l_next, spec_nan, spec_next;
    logic [EXP_W+MAN_W-1:0]  mag_a, mag_b;
    logic [MAN_W:0]          sig_a, sig_b, sig_s;
    logic [EXT_W-1:0]        sig_l_next, sig_s_next;
    logic [EXT_W+SH_LIM-1:0] wide_s;
    logic [W-1:0]            spec_val_next;

    always_comb begin
        ea     = a_reg[W-2 -: EXP_W];
        eb     = b_reg[W-2 -: EXP_W];
        ma     = a_reg[MAN_W-1:0];
        mb     = b_reg[MAN_W-1:0];
        sa     = a_reg[W-1];
        sb_eff = b_reg[W-1] ^ op_reg;   // subtraction is addition of the negated B
        a_max  = &ea;
        b_max  = &eb;
        a_nan  = a_max & (|ma);
        b_nan  = b_max & (|mb);
        a_inf  = a_max & ~(|ma);
        b_inf  = b_max & ~(|mb);

        // Zero exponent flushes the operand to zero, denormals included
        sig_a = (ea == '0) ? '0 : {1'b1, ma};
        sig_b = (eb == '0) ? '0 : {1'b1, mb};
        mag_a = (ea == '0) ? '0 : {ea, ma};
        mag_b = (eb == '0) ? '0 : {eb, mb};
        swap  = mag_b > mag_a;

        el          = swap ? eb : ea;
        es          = swap ? ea : eb;
        diff        = el - es;
        sign_l_next = swap ? sb_eff : sa;
        sig_l_next  = {(swap ? sig_b : sig_a), 3'b000};
        sig_s       = swap ? sig_a : sig_b;
        wide_s      = {sig_s, 3'b000, {SH_LIM{1'b0}}} >> diff;
        if (int'(diff) >= SH_LIM) begin
            sig_s_next = {{(EXT_W-1){1'b0}}, |sig_s};
        end else begin
            sig_s_next = {wide_s[EXT_W+SH_LIM-1:SH_LIM+1],
                          wide_s[SH_LIM] | (|wide_s[SH_LIM-1:0])};
        end

        spec_nan  = a_nan | b_nan | (a_inf & b_inf & (sa ^ sb_eff));
        spec_next = a_max | b_max;
        if (spec_nan) begin
            spec_val_next = QNAN;
        end else if (a_inf) begin
            spec_val_next = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            spec_val_next = {sb_eff, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    // ---------------- normalisation and rounding ----------------
    logic                   carry, sum_zero, found, underflow, overflow, round_up, zero_sign;
    logic [LZC_W-1:0]       lzc, lzc_eff;
    logic [EXT_W-1:0]       norm;
    logic [EXP_W+1:0]       exp_n, exp_r;
    logic [MAN_W:0]         mant_r;
    logic [W-1:0]           norm_val;
    logic                   grs_unused;

    always_comb begin
        lzc   = '0;
        found = 1'b0;
        for (int i = EXT_W - 1; i >= 0; i--) begin
            if (!found) begin
                if (sum_reg[i]) found = 1'b1;
                else            lzc   = lzc + 1'b1;
            end
        end

        carry    = sum_reg[SUM_W-1];
        sum_zero = (sum_reg == '0);
        lzc_eff  = carry ? '0 : lzc;
        norm     = carry ? {sum_reg[SUM_W-1:2], |sum_reg[1:0]}
                         : (sum_reg[EXT_W-1:0] << lzc);
        // Two spare exponent bits: the top one flags a negative (underflowed) exponent
        exp_n     = {2'b00, exp_l_reg} + {{(EXP_W+1){1'b0}}, carry} - (EXP_W+2)'(lzc_eff);
        underflow = exp_n[EXP_W+1] | (exp_n == '0);
`ifdef FPU_ROUND_RNE_EN
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
        round_up = 1'b0;
`endif
        mant_r    = {1'b0, norm[EXT_W-2:3]} + {{MAN_W{1'b0}}, round_up};
        exp_r     = exp_n + {{(EXP_W+1){1'b0}}, mant_r[MAN_W]};
        overflow  = exp_r >= {2'b00, {EXP_W{1'b1}}};
        zero_sign = sign_l_reg & ~eff_sub_reg;   // only (-0)+(-0) keeps a negative zero

        if (special_reg) begin
            norm_val = special_val_reg;
        end else if (sum_zero) begin
            norm_val = {zero_sign, {(W-1){1'b0}}};
        end else if (underflow) begin
            norm_val = {sign_l_reg, {(W-1){1'b0}}};
        end else if (overflow) begin
            norm_val = {sign_l_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            norm_val = {sign_l_reg, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
        end
    end

    assign grs_unused = ^{norm[EXT_W-1], norm[2:0]};

    // ---------------- control and datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            in_ready        <= 1'b1;
            out_valid       <= 1'b0;
            result          <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            op_reg          <= 1'b0;
            sign_l_reg      <= 1'b0;
            eff_sub_reg     <= 1'b0;
            special_reg     <= 1'b0;
            exp_l_reg       <= '0;
            sig_l_reg       <= '0;
            sig_s_reg       <= '0;
            special_val_reg <= '0;
            sum_reg         <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= operA;
                        b_reg     <= operB;
                        op_reg    <= operation;
                        in_ready  <= 1'b0;
                        state_reg <= ALIGN;
                    end
                end
                ALIGN: begin
                    sign_l_reg      <= sign_l_next;
                    eff_sub_reg     <= sa ^ sb_eff;
                    exp_l_reg       <= el;
                    sig_l_reg       <= sig_l_next;
                    sig_s_reg       <= sig_s_next;
                    special_reg     <= spec_next;
                    special_val_reg <= spec_val_next;
                    state_reg       <= ADD;
                end
                ADD: begin
                    // Larger magnitude is first, so the difference never goes negative
                    sum_reg   <= eff_sub_reg ? ({1'b0, sig_l_reg} - {1'b0, sig_s_reg})
                                             : ({1'b0, sig_l_reg} + {1'b0, sig_s_reg});
                    state_reg <= NORM;
                end
                NORM: begin
                    result    <= norm_val;
                    out_valid <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Bench for fpu_addsub_seq: directed corner cases plus random operands against an exact-arithmetic model.
module tb_fpu_addsub_seq;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, operation, out_valid, out_ready;
    logic [31:0] operA, operB, result;
    int          compared = 0;
    int          mismatched = 0;

`ifdef FPU_ROUND_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    fpu_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .operation(operation), .operA(operA), .operB(operB),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Exact value arithmetic on wide integers; a far-smaller operand is replaced by an
    // infinitesimal, which leaves truncation and nearest-even rounding unchanged.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic op);
        int ea, eb, e_hi, e_min, e_lo, p, e, sh;
        logic sa, sb, sgn;
        logic [127:0] va, vb, mag, q, rem, half;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        sa = a[31];
        sb = b[31] ^ op;
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
        if (ea == 255 && eb == 255) return (sa != sb) ? 32'h7FC00000 : {sa, 8'hFF, 23'h0};
        if (ea == 255) return {sa, 8'hFF, 23'h0};
        if (eb == 255) return {sb, 8'hFF, 23'h0};
        e_hi  = (ea > eb) ? ea : eb;
        e_min = (ea > eb) ? eb : ea;
        e_lo  = (e_min >= e_hi - 40) ? e_min : e_hi - 40;
        if (ea == 0)          va = '0;
        else if (ea >= e_lo)  va = 128'({1'b1, a[22:0]}) << (ea - e_lo);
        else                  va = 128'd1;
        if (eb == 0)          vb = '0;
        else if (eb >= e_lo)  vb = 128'({1'b1, b[22:0]}) << (eb - e_lo);
        else                  vb = 128'd1;
        if (sa == sb)      begin mag = va + vb; sgn = sa; end
        else if (va >= vb) begin mag = va - vb; sgn = sa; end
        else               begin mag = vb - va; sgn = sb; end
        if (mag == 0) return {sa & sb, 31'h0};
        p = 127;
        while (!mag[p]) p--;
        e = e_lo + p - 23;
        if (p > 23) begin
            sh   = p - 23;
            q    = mag >> sh;
            rem  = mag & ((128'd1 << sh) - 1);
            half = 128'd1 << (sh - 1);
        end else begin
            q    = mag << (23 - p);
            rem  = '0;
            half = 128'd1;
        end
        if (e <= 0) return {sgn, 31'h0};
        if (RNE && (rem > half || (rem == half && q[0]))) begin
            q = q + 1;
            if (q[24]) begin
                q = q >> 1;
                e++;
            end
        end
        if (e >= 255) return {sgn, 8'hFF, 23'h0};
        return {sgn, e[7:0], q[22:0]};
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic [31:0] exp);
        int lat;
        @(negedge clk);
        operA = a; operB = b; operation = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("%s: %h %s %h -> %h (expect %h, %0d edges)", tag, a, op ? "-" : "+", b, result, exp, lat);
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check(tag, result, exp);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [31:0] ra, rb;
    logic        rop;
    int          mode;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; operation = 1'b0;
        operA = '0; operB = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'h0);
        @(negedge clk); rst = 1'b0;

        run_op("add_basic", 32'h40600000, 32'h3FA00000, 1'b0, 32'h40980000);
        run_op("sub_basic", 32'h40600000, 32'h3FA00000, 1'b1, 32'h40100000);
        run_op("cancel", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000);
        run_op("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000);
        run_op("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000);
        run_op("round", 32'h3F800000, 32'h33C00000, 1'b0, RNE ? 32'h3F800001 : 32'h3F800000);
        run_op("pz_nz", 32'h00000000, 32'h80000000, 1'b0, 32'h00000000);
        run_op("nz_nz", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000);
        run_op("denorm", 32'h00400000, 32'h3F800000, 1'b1, 32'hBF800000);
        run_op("inf_fin", 32'h40000000, 32'h7F800000, 1'b1, 32'hFF800000);
        run_op("nan_in", 32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000);

        // Hold in DONE with out_ready low; a stray in_valid pulse must not disturb anything
        @(negedge clk); operA = 32'h40600000; operB = 32'h3FA00000; operation = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("hold_enter", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 2);
            operA = 32'h3F800000; operB = 32'h3F800000;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", result, 32'h40980000);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("no_capture_in_ready", 32'(in_ready), 32'd1);
        check("no_capture_valid", 32'(out_valid), 32'd0);

        // Reset while the operation sits in ADD
        @(negedge clk); operA = 32'h40600000; operB = 32'h3FA00000; operation = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", result, 32'h0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("midrst_no_valid", 32'(out_valid), 32'd0);
        end

        // Reset and in_valid on the same edge: nothing may be captured
        @(negedge clk); rst = 1'b1; in_valid = 1'b1; operA = 32'h3F800000; operB = 32'h3F800000;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("rst_win_in_ready", 32'(in_ready), 32'd1);
            check("rst_win_valid", 32'(out_valid), 32'd0);
        end
        run_op("after_rst", 32'h40600000, 32'h3FA00000, 1'b1, 32'h40100000);

        for (int n = 0; n < 300; n++) begin
            ra   = $urandom;
            rb   = $urandom;
            rop  = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 5);
            case (mode)
                1: rb[30:23] = ra[30:23] + 8'($urandom_range(0, 4)) - 8'd2;
                2: rb = ra ^ 32'($urandom_range(0, 255)) ^ {1'($urandom_range(0, 1)), 31'h0};
                3: rb[30:23] = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
                4: rb[30:23] = ra[30:23] - 8'($urandom_range(20, 30));
                5: begin
                    ra[30:23] = 8'($urandom_range(1, 3));
                    rb[30:23] = 8'($urandom_range(1, 3));
                end
                default: ;
            endcase
            run_op("rand", ra, rb, rop, ref_add(ra, rb, rop));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
